// File: rtl/digital_tube_driver.sv
// digital_tube_driver: memory-mapped 4-digit common-anode 7-segment scan driver
// with a per-slot blanking window that hides ghosting between digits.
module digital_tube_driver #(
    parameter int          SCAN_DIV  = 50000,
    parameter int          BLANK_CYC = 16,
    parameter logic [31:0] ADDR_DATA = 32'h4000_0010,
    parameter logic [31:0] ADDR_CTRL = 32'h4000_0014,
    parameter logic [31:0] ADDR_STAT = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [11:0] real_digital
);
    localparam int CW = $clog2(SCAN_DIV);
    // active-high gfedcba patterns, digit 0 in the low 7 bits
    localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic [15:0]   data_q;
    logic          en_q;
    logic [3:0]    dp_q, blank_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   pins_q, pins_d;
    logic [3:0]    nib;
    logic          lit, wrap, wr_data, wr_ctrl;
    logic          unused_wd;

    assign unused_wd    = ^{write_data[31:12], write_data[3:1]};
    assign real_digital = pins_q;

    always_comb begin
        wr_data   = mem_write && addr == ADDR_DATA;
        wr_ctrl   = mem_write && addr == ADDR_CTRL;
        wrap      = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d     = (!en_q || wrap) ? '0 : cnt_q + 1'b1;
        idx_d     = !en_q ? 2'd0 : wrap ? idx_q + 2'd1 : idx_q;
        nib       = data_q[{idx_q, 2'b00} +: 4];
        lit       = en_q && cnt_q >= CW'(BLANK_CYC) && !blank_q[idx_q];
        pins_d    = lit ? {~(4'b0001 << idx_q), ~dp_q[idx_q], ~HEX[7*nib +: 7]} : 12'hFFF;
        read_data = !mem_read              ? 32'd0 :
                    addr == ADDR_DATA      ? {16'd0, data_q} :
                    addr == ADDR_CTRL      ? {20'd0, blank_q, dp_q, 3'd0, en_q} :
                    addr == ADDR_STAT      ? {29'd0, en_q, idx_q} : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            en_q    <= 1'b0;
            dp_q    <= '0;
            blank_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            pins_q  <= 12'hFFF;
        end else begin
            if (wr_data)
                data_q <= write_data[15:0];
            if (wr_ctrl) begin
                en_q    <= write_data[0];
                dp_q    <= write_data[7:4];
                blank_q <= write_data[11:8];
            end
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pins_q <= pins_d;
        end
    end
endmodule

// File: tb/tb_digital_tube_driver.sv
// tb_digital_tube_driver: directed bench with a cycle-level behavioural model of the
// display (position counted as cycles since enable) plus hand-computed pin values.
module tb_digital_tube_driver;
    localparam logic [31:0] A_DATA = 32'h4000_0010;
    localparam logic [31:0] A_CTRL = 32'h4000_0014;
    localparam logic [31:0] A_STAT = 32'h4000_0018;
    localparam logic [31:0] A_NONE = 32'h4000_0020;

    logic        clk = 1'b0, reset = 1'b1, mem_write = 1'b0, mem_read = 1'b0;
    logic [31:0] addr = '0, write_data = '0;
    logic [31:0] read_data;
    logic [11:0] real_digital;
    int          n_cmp = 0, n_bad = 0;
    bit          started = 1'b0;

    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_data = '0;
    logic [11:0] m_ctrl = '0;
    int          m_n = 0;
    logic [11:0] m_pins = 12'hFFF;

    digital_tube_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .real_digital(real_digital)
    );

    always #5 clk = ~clk;

    // m_n counts cycles since scanning began: slot = n/8, position in slot = n%8
    function automatic logic [11:0] pins_of(logic [15:0] d, logic [11:0] c, int n);
        int dig = (n / 8) % 4;
        int ph = n % 8;
        logic [3:0] nib = d[dig*4 +: 4];
        if (!c[0] || ph < 2 || c[8+dig]) return 12'hFFF;
        return {~(4'b0001 << dig), ~c[4+dig], ~hex_tab[nib]};
    endfunction

    function automatic logic [31:0] read_of();
        if (!mem_read) return 32'd0;
        if (addr == A_DATA) return {16'd0, m_data};
        if (addr == A_CTRL) return {20'd0, m_ctrl};
        if (addr == A_STAT) return {29'd0, m_ctrl[0], 2'((m_n / 8) % 4)};
        return 32'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0;
            m_ctrl <= '0;
            m_n    <= 0;
            m_pins <= 12'hFFF;
        end else begin
            m_pins <= pins_of(m_data, m_ctrl, m_n);
            m_n    <= m_ctrl[0] ? m_n + 1 : 0;
            if (mem_write && addr == A_DATA) m_data <= write_data[15:0];
            if (mem_write && addr == A_CTRL) m_ctrl <= write_data[11:0] & 12'hFF1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_pins", {20'd0, real_digital}, {20'd0, m_pins});
            check("model_rdata", read_data, read_of());
        end
    end

    task automatic tick(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        addr = a;
        write_data = d;
        mem_write = 1'b1;
        tick(1);
        mem_write = 1'b0;
        addr = '0;
        write_data = '0;
    endtask

    task automatic rd(logic [31:0] a, string name, logic [31:0] exp);
        addr = a;
        mem_read = 1'b1;
        #1 check(name, read_data, exp);
        mem_read = 1'b0;
        addr = '0;
    endtask

    task automatic pins(string name, logic [11:0] exp);
        check(name, {20'd0, real_digital}, {20'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 200000);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        started = 1'b1;
        pins("reset_pins", 12'hFFF);
        rd(A_DATA, "reset_data", 32'd0);
        rd(A_CTRL, "reset_ctrl", 32'd0);
        rd(A_STAT, "reset_stat", 32'd0);
        reset = 1'b0;
        tick(1);
        wr(A_DATA, 32'h0000_1234);
        wr(A_CTRL, 32'h0000_0001);
        tick(2);  pins("slot0_blank", 12'hFFF);
        tick(1);  pins("slot0_first", 12'hE99);
        tick(5);  pins("slot0_last", 12'hE99);
        tick(1);  pins("slot1_blank", 12'hFFF);
        tick(2);  pins("slot1_lit", 12'hDB0);
        rd(A_STAT, "stat_slot1", 32'd5);
        tick(8);  pins("slot2_lit", 12'hBA4);
        tick(8);  pins("slot3_lit", 12'h7F9);
        tick(4);  rd(A_STAT, "stat_slot3", 32'd7);
        tick(1);  rd(A_STAT, "stat_wrap", 32'd4);
        tick(1);  pins("wrap_blank", 12'hFFF);
        tick(2);  pins("wrap_lit", 12'hE99);
        wr(A_CTRL, 32'h0000_0211);
        rd(A_CTRL, "ctrl_readback", 32'h0000_0211);
        tick(31); pins("dp_digit0", 12'hE19);
        tick(5);  pins("dp_digit0_end", 12'hE19);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            pins("blanked_digit1", 12'hFFF);
        end
        tick(4);
        wr(A_CTRL, 32'd0);
        pins("disable_edge", 12'hBA4);
        tick(1);  pins("disabled", 12'hFFF);
        rd(A_STAT, "stat_disabled", 32'd0);
        tick(3);
        wr(A_CTRL, 32'h0000_0001);
        tick(2);  pins("reenable_blank", 12'hFFF);
        tick(1);  pins("reenable_lit", 12'hE99);
        wr(A_DATA, 32'hFFFF_ABCD);
        wr(A_NONE, 32'h1111_2222);
        rd(A_DATA, "data_upper_zero", 32'h0000_ABCD);
        rd(A_NONE, "unmapped_read", 32'd0);
        addr = A_DATA;
        #1 check("no_read_strobe", read_data, 32'd0);
        write_data = 32'h0000_5678;
        mem_write = 1'b1;
        mem_read = 1'b1;
        #1 check("rw_same_cycle_old", read_data, 32'h0000_ABCD);
        tick(1);
        mem_write = 1'b0;
        mem_read = 1'b0;
        rd(A_DATA, "rw_new_value", 32'h0000_5678);
        wr(A_CTRL, 32'd0);
        tick(1);
        wr(A_CTRL, 32'h0000_0001);
        tick(3);  pins("pre_reset_lit", 12'hE80);
        #2 reset = 1'b1;
        #1 pins("reset_async", 12'hFFF);
        tick(1);
        rd(A_DATA, "midreset_data", 32'd0);
        rd(A_CTRL, "midreset_ctrl", 32'd0);
        rd(A_STAT, "midreset_stat", 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/digital_tube_driver.md
# digital_tube_driver

Memory-mapped scan driver for the board's 4-digit, common-anode seven-segment display. The CPU writes four hex nibbles and a control word over its data-memory bus. The block time-multiplexes the digits onto the 12-bit `real_digital` pin group, with a per-slot blanking window that suppresses ghosting. It sits beside the CPU's data memory on the divided CPU clock.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `ADDR_DATA`, 32'h4000_0010: DATA register address.
- `ADDR_CTRL`, 32'h4000_0014: CTRL register address.
- `ADDR_STAT`, 32'h4000_0018: STATUS register address (read-only).
- `reset` input 1: asynchronous, active-high.
- `clk` input 1: single clock; all state on its rising edge.
- `mem_write` input 1: write strobe, one word per asserted cycle.
- `mem_read` input 1: read strobe.
- `addr` input 32: byte address, full-word decode.
- `write_data` input 32: write data.
- `read_data` output 32: combinational read data.
- `real_digital` output 12: registered. `[11:8]` anodes for digits 3..0, active-low. `[7:0]` segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- DATA register: `[15:0]` hold four nibbles, digit i = `[4i+3:4i]`, digit 0 rightmost. Bits `[31:16]` read back as 0.
- CTRL register: bit0 = enable, `[7:4]` = dp mask (bit 4+i lights the dp of digit i), `[11:8]` = blank mask (bit 8+i blanks digit i). Other bits read as 0.
- STATUS register: `[1:0]` = current digit index, bit2 = enable. Writes to STATUS are ignored.
- Writes to any other address are ignored. Reads of any other address, or with `mem_read`=0, return 0.
- Scan state: `cnt` in 0..`SCAN_DIV`-1 and `idx` in 0..3.
- While enabled, `cnt` increments each cycle. At `cnt`=`SCAN_DIV`-1, `cnt` returns to 0 and `idx` advances to (`idx`+1) mod 4, wrapping 3→0.
- While disabled, `cnt` and `idx` are held at 0.
- Digit `idx` is lit when enable=1, `cnt` ≥ `BLANK_CYC`, and blank bit `idx`=0.
- When lit: anode `idx` is low and the other anodes are high. Segments = ~hex(nibble `idx`). dp = ~dpmask[`idx`].
- When not lit: `real_digital` = 12'hFFF.
- Hex decode table, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.

## Timing
- During reset: DATA=0, CTRL=0, `cnt`=0, `idx`=0, `real_digital`=12'hFFF. `read_data` follows the reset register values.
- Reset asserted mid-scan takes effect immediately (asynchronous) and forces the same values.
- A write is registered on the edge where `mem_write`=1. `real_digital` is computed from the pre-edge `cnt`, `idx` and registers. New DATA is therefore visible on the pins one cycle after the write edge, provided the digit is lit.
- Read and write to the same address in the same cycle: `read_data` returns the old value.
- Enable 0→1: scanning starts at `idx`=0, `cnt`=0. The first lit output appears `BLANK_CYC`+1 cycles after the write edge.
- Enable 1→0 mid-slot: `cnt` and `idx` clear on the next edge. `real_digital`=12'hFFF from the cycle after the write edge.
- Re-writing CTRL with enable=1 while already enabled does not restart the scan.
- Each slot lasts exactly `SCAN_DIV` cycles. A full frame lasts 4·`SCAN_DIV` cycles.
- No data shadowing: a mid-slot DATA write changes the lit digit immediately. This is accepted.

## Test plan
Bench parameters: `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset: assert `reset` mid-scan. Required: `real_digital`=12'hFFF at once; DATA, CTRL and STATUS all read 0.
- Write DATA=32'h1234, then CTRL=1. Required per slot:
  - slot 0 shows 12'hE99 for 6 cycles after 2 off cycles;
  - slot 1 shows 12'hDB0;
  - `idx` wraps 3→0 after 32 cycles;
  - STATUS reads 5 in slot 1.
- Write CTRL=32'h0000_0211 (dp digit 0, blank digit 1). Required: slot 0 shows 12'hE19; slot 1 stays 12'hFFF for all 8 cycles.
- In slot 2, cycle 4, write CTRL=0. Required: 12'hFFF from the next cycle; STATUS reads 0. Re-enable: the first lit value is digit 0 after 2 blank cycles.
- Write 32'hFFFF_ABCD to DATA, then to address 32'h4000_0020, then read both. Required: DATA reads 32'h0000_ABCD; the unmapped read returns 0. Same-cycle read and write of DATA returns the old value.
